// File: rtl/vga_pattern_sequencer.sv
// VGA pattern sequencer: debounces the three board keys, runs a MANUAL/AUTO
// mode machine and produces frame-synchronous pattern select and scroll
// offsets. Every visible output changes only on the cycle after frame_tick.
module vga_pattern_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned N_PATTERNS      = 4,
   parameter int unsigned OFFSET_WIDTH    = 8,
   parameter int unsigned HOLD_FRAMES     = 60,
   parameter int unsigned AUTO_FRAMES     = 120
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              key,
   input  logic                    vsync,
   output logic [1:0]              pattern_sel,
   output logic [OFFSET_WIDTH-1:0] dx,
   output logic [OFFSET_WIDTH-1:0] dy,
   output logic                    auto_mode,
   output logic                    frame_tick
);

   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned AutoW = $clog2(AUTO_FRAMES + 1);

   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES);
   localparam logic [HoldW-1:0] HoldFire = HoldW'(HOLD_FRAMES - 1);
   localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_FRAMES - 1);
   localparam logic [1:0]       SelLast  = 2'(N_PATTERNS - 1);

   typedef enum logic [0:0] {StManual, StAuto} state_e;

   logic [2:0]     key_s1, key_s2;
   logic [1:0]     prime_q;
   logic [2:0]     armed_q;
   logic [2:0]     pressed_q;
   logic [DbW-1:0] db_cnt_q [3];

   logic vs_q, vs_hist_q;

   state_e           state_q;
   logic [HoldW-1:0] hold_q;
   logic [AutoW-1:0] auto_cnt_q;
   logic             pending_q;
   logic             p0_prev_q;
   logic             short_press;
   logic             long_fire;
   logic [1:0]       next_sel;

   // Synchronize the keys and debounce them; a key only becomes usable after it
   // has been seen stably released, so a press held through reset is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_s1    <= '1;
         key_s2    <= '1;
         prime_q   <= '0;
         armed_q   <= '0;
         pressed_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         key_s1  <= key;
         key_s2  <= key_s1;
         // key_s2 holds reset values until two clocks have passed
         prime_q <= {prime_q[0], 1'b1};
         for (int i = 0; i < 3; i++) begin
            if (!armed_q[i]) begin
               if (prime_q[1] && key_s2[i]) begin
                  if (db_cnt_q[i] == DbLast) begin
                     armed_q[i]  <= 1'b1;
                     db_cnt_q[i] <= '0;
                  end else begin
                     db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                  end
               end else begin
                  db_cnt_q[i] <= '0;
               end
            end else if (~key_s2[i] != pressed_q[i]) begin
               if (db_cnt_q[i] == DbLast) begin
                  pressed_q[i] <= ~key_s2[i];
                  db_cnt_q[i]  <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   // Register vsync and pulse frame_tick the cycle after a falling edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_q       <= 1'b1;
         vs_hist_q  <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vs_q       <= vsync;
         vs_hist_q  <= vs_q;
         frame_tick <= vs_hist_q & ~vs_q;
      end
   end

   // Press classification and pattern wrap.
   always_comb begin
      short_press = p0_prev_q & ~pressed_q[0] & (hold_q != HoldMax);
      long_fire   = frame_tick & pressed_q[0] & (hold_q == HoldFire);
      next_sel    = (pattern_sel == SelLast) ? 2'd0 : pattern_sel + 2'd1;
   end

   // Mode machine, hold/auto counters and frame-synchronous outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StManual;
         pattern_sel <= '0;
         dx          <= '0;
         dy          <= '0;
         hold_q      <= '0;
         auto_cnt_q  <= '0;
         pending_q   <= 1'b0;
         p0_prev_q   <= 1'b0;
      end else begin
         p0_prev_q <= pressed_q[0];
         if (!pressed_q[0]) begin
            hold_q <= '0;
         end else if (frame_tick && hold_q != HoldMax) begin
            hold_q <= hold_q + HoldW'(1);
         end
         if (frame_tick) begin
            if (pressed_q[2]) dx <= dx + OFFSET_WIDTH'(1);
            if (pressed_q[1]) dy <= dy + OFFSET_WIDTH'(1);
            if (long_fire) begin
               // long press wins over any pending short-press advance
               state_q    <= (state_q == StManual) ? StAuto : StManual;
               auto_cnt_q <= '0;
               pending_q  <= 1'b0;
            end else if (state_q == StManual) begin
               if (pending_q) begin
                  pattern_sel <= next_sel;
                  pending_q   <= 1'b0;
               end
            end else if (auto_cnt_q == AutoLast) begin
               pattern_sel <= next_sel;
               auto_cnt_q  <= '0;
            end else begin
               auto_cnt_q <= auto_cnt_q + AutoW'(1);
            end
         end
         // after the frame update so a release on the tick cycle is not lost
         if (short_press && state_q == StManual) pending_q <= 1'b1;
      end
   end

   assign auto_mode = (state_q == StAuto);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer: each directed frame pushes its
// hand-computed expected outputs; a monitor pops and compares after every tick.
module tb_vga_pattern_sequencer;

   localparam int unsigned OW = 8;

   typedef struct packed {
      logic [1:0]    sel;
      logic [OW-1:0] dx;
      logic [OW-1:0] dy;
      logic          am;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    key = 3'b000;
   logic          vsync = 1'b1;
   logic [1:0]    pattern_sel;
   logic [OW-1:0] dx;
   logic [OW-1:0] dy;
   logic          auto_mode;
   logic          frame_tick;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   vga_pattern_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .N_PATTERNS     (4),
      .OFFSET_WIDTH   (OW),
      .HOLD_FRAMES    (3),
      .AUTO_FRAMES    (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .vsync      (vsync),
      .pattern_sel(pattern_sel),
      .dx         (dx),
      .dy         (dy),
      .auto_mode  (auto_mode),
      .frame_tick (frame_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One 100-clock frame: four 12-clock key phases, then a 10-clock vsync pulse.
   task automatic run_frame(input logic [2:0] k0, input logic [2:0] k1, input logic [2:0] k2,
                            input logic [2:0] k3, input logic [1:0] esel,
                            input logic [OW-1:0] edx, input logic [OW-1:0] edy, input logic eam);
      exp_t e;
      key = k0; cyc(12);
      key = k1; cyc(12);
      key = k2; cyc(12);
      key = k3; cyc(12);
      e.sel = esel; e.dx = edx; e.dy = edy; e.am = eam;
      exp_q.push_back(e);
      vsync = 1'b0; cyc(10);
      vsync = 1'b1; cyc(42);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_tick: %0d expected frames unconsumed, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic frame(input logic [2:0] k, input logic [1:0] esel, input logic [OW-1:0] edx,
                        input logic [OW-1:0] edy, input logic eam);
      run_frame(k, k, k, k, esel, edx, edy, eam);
   endtask

   // Monitor: compare after each tick, otherwise require outputs to hold.
   initial begin
      exp_t e;
      exp_t prev;
      exp_t cur;
      logic cmp_pend;
      logic prev_valid;
      cmp_pend   = 1'b0;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         cur.sel = pattern_sel; cur.dx = dx; cur.dy = dy; cur.am = auto_mode;
         if (!rst_n) begin
            cmp_pend   = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (cmp_pend) begin
               e = exp_q.pop_front();
               check("pattern_sel", 32'(pattern_sel), 32'(e.sel));
               check("dx", 32'(dx), 32'(e.dx));
               check("dy", 32'(dy), 32'(e.dy));
               check("auto_mode", 32'(auto_mode), 32'(e.am));
               check("tick_width", 32'(frame_tick), 32'(0));
               cmp_pend = 1'b0;
            end else if (prev_valid) begin
               check("stable_outputs", 32'(cur), 32'(prev));
            end
            if (frame_tick === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_tick: tick at %0t with no frame expected", $time);
               end else begin
                  cmp_pend = 1'b1;
               end
            end
            prev       = cur;
            prev_valid = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      // Reset with all keys pressed
      rst_n = 1'b0; key = 3'b000; vsync = 1'b1;
      cyc(3);
      @(negedge clk);
      check("rst_pattern_sel", 32'(pattern_sel), 32'(0));
      check("rst_dx", 32'(dx), 32'(0));
      check("rst_dy", 32'(dy), 32'(0));
      check("rst_auto_mode", 32'(auto_mode), 32'(0));
      check("rst_frame_tick", 32'(frame_tick), 32'(0));
      cyc(1);
      rst_n = 1'b1;

      // Keys still held from reset: no action
      frame(3'b000, 2'd0, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd0, 8'd0, 8'd0, 1'b0);

      // Bounce on key[0] never settles
      for (int i = 0; i < 10; i++) begin
         key = (i % 2 == 0) ? 3'b110 : 3'b111;
         cyc(2);
      end
      frame(3'b111, 2'd0, 8'd0, 8'd0, 1'b0);

      // Four short presses
      frame(3'b110, 2'd0, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd2, 8'd0, 8'd0, 1'b0);
      frame(3'b110, 2'd2, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd3, 8'd0, 8'd0, 1'b0);
      frame(3'b110, 2'd3, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd0, 8'd0, 8'd0, 1'b0);

      // Two short presses inside one frame advance once
      run_frame(3'b110, 3'b111, 3'b110, 3'b111, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd1, 8'd0, 8'd0, 1'b0);

      // Long press into AUTO, advancing every two frames
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b1);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b1);
      frame(3'b110, 2'd2, 8'd0, 8'd0, 1'b1);
      frame(3'b111, 2'd2, 8'd0, 8'd0, 1'b1);
      frame(3'b111, 2'd3, 8'd0, 8'd0, 1'b1);

      // Short press in AUTO does nothing extra
      frame(3'b110, 2'd3, 8'd0, 8'd0, 1'b1);
      frame(3'b111, 2'd0, 8'd0, 8'd0, 1'b1);

      // Second long press back to MANUAL
      frame(3'b110, 2'd0, 8'd0, 8'd0, 1'b1);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b1);
      frame(3'b110, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd1, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd1, 8'd0, 8'd0, 1'b0);

      // Offsets: 260 frames with key[2] and key[1] held, wrapping past 255
      for (int n = 1; n <= 260; n++) begin
         frame(3'b001, 2'd1, 8'(n), 8'(n), 1'b0);
      end
      frame(3'b111, 2'd1, 8'd4, 8'd4, 1'b0);

      // Enter AUTO with key[2] held, then reset mid-operation
      frame(3'b010, 2'd1, 8'd5, 8'd4, 1'b0);
      frame(3'b010, 2'd1, 8'd6, 8'd4, 1'b0);
      frame(3'b010, 2'd1, 8'd7, 8'd4, 1'b1);
      frame(3'b011, 2'd1, 8'd8, 8'd4, 1'b1);
      rst_n = 1'b0;
      cyc(1);
      @(negedge clk);
      check("midrst_auto_mode", 32'(auto_mode), 32'(0));
      check("midrst_dx", 32'(dx), 32'(0));
      check("midrst_dy", 32'(dy), 32'(0));
      check("midrst_pattern_sel", 32'(pattern_sel), 32'(0));
      cyc(1);
      rst_n = 1'b1;
      frame(3'b011, 2'd0, 8'd0, 8'd0, 1'b0);
      frame(3'b111, 2'd0, 8'd0, 8'd0, 1'b0);
      frame(3'b011, 2'd0, 8'd1, 8'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
